// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC divider: FSM state encoding and
// quotient-width / unity-constant helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_t;

  // Quotient carries a sign bit, one integer bit and frac_w fraction bits.
  function automatic int z_width(input int frac_w);
    return frac_w + 2;
  endfunction

  // Fixed-point 1.0 in the quotient format.
  function automatic longint unsigned one_value(input int frac_w);
    return 64'd1 << frac_w;
  endfunction

endpackage

// File: rtl/cordic_div_iter_if.sv
// Operand/result handshake bundle for cordic_div_iter.
// master: producer/consumer side, slave: divider side.
interface cordic_div_iter_if
  import cordic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 15
);
  localparam int Z_W = z_width(FRAC_W);

  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_x;
  logic [DATA_W-1:0] rx_y;
  logic              tx_valid;
  logic              tx_ready;
  logic [Z_W-1:0]    tx_z;
  logic              tx_err;

  modport master (
    output rx_valid, rx_x, rx_y, tx_ready,
    input  rx_ready, tx_valid, tx_z, tx_err
  );

  modport slave (
    input  rx_valid, rx_x, rx_y, tx_ready,
    output rx_ready, tx_valid, tx_z, tx_err
  );

endinterface

// File: rtl/cordic_div_step.sv
// One linear-vectoring CORDIC micro-rotation (combinational). Drives y toward
// zero by x>>>sh and accumulates the matching +/-ONE>>sh into the quotient.
module cordic_div_step
  import cordic_pkg::*;
#(
  parameter int XY_W   = 34,
  parameter int FRAC_W = 15,
  parameter int I_W    = 6,
  parameter int Z_W    = z_width(FRAC_W)
) (
  input  logic signed [XY_W-1:0] x,
  input  logic signed [XY_W-1:0] y,
  input  logic signed [Z_W-1:0]  z,
  input  logic        [I_W-1:0]  sh,
  output logic signed [XY_W-1:0] y_next,
  output logic signed [Z_W-1:0]  z_next
);
  localparam logic [Z_W-1:0] ONE = Z_W'(one_value(FRAC_W));

  logic signed [XY_W-1:0] x_sh;
  logic        [Z_W-1:0]  one_sh;

  assign x_sh   = x >>> sh;
  assign one_sh = ONE >> sh;

  // Rotate toward y==0: sign of the residual picks the direction.
  always_comb begin
    y_next = y;
    z_next = z;
    if (y[XY_W-1]) begin
      y_next = y + x_sh;
      z_next = z - signed'(one_sh);
    end else begin
      y_next = y - x_sh;
      z_next = z + signed'(one_sh);
    end
  end

endmodule

// File: rtl/cordic_div_iter.sv
// Iterative CORDIC divider: tx_z = rx_y / rx_x in signed fixed point with
// FRAC_W fraction bits, one micro-rotation per clock, ITER rotations per
// division. Optional macro CORDIC_DIV_ZERO_CHK_EN flags rx_x==0 and forces
// tx_z to zero for that result.
module cordic_div_iter
  import cordic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 15,
  parameter int ITER   = 16
) (
  input logic               rx_clk,
  input logic               rx_rst_n,
  cordic_div_iter_if.slave  bus
);
  localparam int XY_W = DATA_W + 2;
  localparam int Z_W  = z_width(FRAC_W);
  localparam int I_W  = $clog2(XY_W);
  localparam logic [I_W-1:0] I_LAST = I_W'(ITER - 1);

  cordic_state_t state, state_next;

  logic signed [XY_W-1:0] x, y, y_next;
  logic signed [Z_W-1:0]  z, z_next;
  logic        [I_W-1:0]  i;
  logic                   err;

  logic signed [XY_W-1:0] x_in, y_in, x_abs, y_abs, x_load, y_load;
  logic                   err_in;
  logic                   accept, finish, drain;

  // Operands sign-extended into the widened datapath so negating the most
  // negative value and doubling |x| cannot overflow.
  assign x_in   = {{2{bus.rx_x[DATA_W-1]}}, bus.rx_x};
  assign y_in   = {{2{bus.rx_y[DATA_W-1]}}, bus.rx_y};
  assign x_abs  = x_in[XY_W-1] ? -x_in : x_in;
  assign y_abs  = y_in[XY_W-1] ? -y_in : y_in;
  assign x_load = x_in[XY_W-1] ? -x_in : x_in;
  assign y_load = x_in[XY_W-1] ? -y_in : y_in;
  assign err_in = (y_abs >= (x_abs <<< 1));

  assign accept = (state == ST_IDLE) && bus.rx_valid;
  assign finish = (state == ST_RUN) && (i == I_LAST);
  assign drain  = (state == ST_DONE) && bus.tx_ready;

  cordic_div_step #(
    .XY_W   (XY_W),
    .FRAC_W (FRAC_W),
    .I_W    (I_W),
    .Z_W    (Z_W)
  ) u_step (
    .x      (x),
    .y      (y),
    .z      (z),
    .sh     (i),
    .y_next (y_next),
    .z_next (z_next)
  );

`ifdef CORDIC_DIV_ZERO_CHK_EN
  logic zero;

  // Divide-by-zero flag captured with the operands.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n)   zero <= 1'b0;
    else if (accept) zero <= (bus.rx_x == '0);
  end
`endif

  // FSM state register.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state and handshake/result outputs.
  always_comb begin
    state_next   = state;
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_z     = z;
    bus.tx_err   = err;
`ifdef CORDIC_DIV_ZERO_CHK_EN
    if (zero) bus.tx_z = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        bus.rx_ready = 1'b1;
        if (accept) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (finish) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.tx_valid = 1'b1;
        if (drain) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, one micro-rotation per RUN cycle; registers are
  // untouched in DONE so the presented result stays stable under backpressure.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      x   <= '0;
      y   <= '0;
      z   <= '0;
      i   <= '0;
      err <= 1'b0;
    end else if (accept) begin
      x   <= x_load;
      y   <= y_load;
      z   <= '0;
      i   <= '0;
`ifdef CORDIC_DIV_ZERO_CHK_EN
      err <= err_in || (bus.rx_x == '0);
`else
      err <= err_in;
`endif
    end else if (state == ST_RUN) begin
      y   <= y_next;
      z   <= z_next;
      i   <= i + 1'b1;
    end
  end

endmodule

// File: doc/cordic_div_iter.md
CORDIC_DIV_ITER -- requirements
Module: cordic_div_iter

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits (signed two's complement).
REQ-002 Parameter FRAC_W, default 15, quotient fractional bits; quotient width Z_W = FRAC_W+2.
REQ-003 Parameter ITER, default 16, CORDIC iterations per division; legal range 1..DATA_W-1.
REQ-004 rx_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rx_rst_n  input  1  reset, synchronous, active-low.
REQ-006 rx_valid  input  1  operand pair present.
REQ-007 rx_ready  output  1  block can accept an operand pair.
REQ-008 rx_x  input  DATA_W  divisor, signed.
REQ-009 rx_y  input  DATA_W  dividend, signed.
REQ-010 tx_valid  output  1  result present.
REQ-011 tx_ready  input  1  downstream accepts result.
REQ-012 tx_z  output  Z_W  quotient y/x, signed, FRAC_W fractional bits.
REQ-013 tx_err  output  1  result invalid (range overflow or, when enabled, divide-by-zero).

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on rx_valid&&rx_ready; RUN->DONE after ITER RUN cycles; DONE->IDLE on tx_valid&&tx_ready.
REQ-015 rx_ready SHALL be 1 only in IDLE; tx_valid SHALL be 1 only in DONE.
REQ-016 On accept: if rx_x<0, load x=-rx_x, y=-rx_y, else x=rx_x, y=rx_y; z loaded 0; iteration counter i loaded 0.
REQ-017 Each RUN cycle: if y<0 then y+=x>>>i, z-=ONE>>i; else y-=x>>>i, z+=ONE>>i; ONE = 1<<FRAC_W; i increments.
REQ-018 Internal x/y datapath SHALL be DATA_W+2 bits wide to prevent overflow of negation and accumulation.
REQ-019 Latency: accept at edge k; tx_valid high after edge k+ITER; tx_z accurate to +/-1 LSB when ITER>=FRAC_W+1.
REQ-020 tx_err=1 when |rx_y| >= 2*|rx_x| (quotient outside (-2,2)), evaluated on accept; tx_z then holds the unconverged CORDIC value.
REQ-021 tx_z and tx_err SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-022 rx_valid during RUN/DONE SHALL be ignored; no operand is captured; next accept earliest in the cycle after the output handshake.
REQ-023 Most negative rx_x (-2^(DATA_W-1)) SHALL be handled correctly via the widened datapath.

Reset
REQ-024 On rx_rst_n=0 at a clock edge: state=IDLE, tx_valid=0, tx_z=0, tx_err=0, internal x/y/z/i=0; rx_ready=1 from the following cycle.
REQ-025 Reset during RUN or DONE SHALL abort the division; no result is presented.

Configuration
REQ-026 Macro CORDIC_DIV_ZERO_CHK_EN defined: rx_x==0 on accept sets tx_err=1, forces tx_z=0, and still takes ITER cycles.
REQ-027 Macro undefined: no zero detection; rx_x==0 yields tx_err per REQ-020 (|y|>=0 true) and the unconverged tx_z.

Structure
REQ-028 Shared package cordic_pkg SHALL hold the FSM state encoding and the ONE/Z_W derivation helpers.
REQ-029 One sub-module cordic_div_step (one combinational linear-vectoring micro-rotation, shift amount as input) SHALL be instantiated once and reused each RUN cycle.

Verification (DATA_W=32, FRAC_W=15, ITER=16)
REQ-030 x=0x8000, y=0x4000 -> tx_valid 16 cycles after accept, tx_z=0x04000 +/-1, tx_err=0.
REQ-031 x=0x8000, y=-0x6000 -> tx_z=0x1A000 +/-1 (-0.75); x=-0x8000, y=0x6000 -> same result.
REQ-032 x=0x1000, y=0x3000 -> tx_err=1.
REQ-033 x=0 with CORDIC_DIV_ZERO_CHK_EN -> tx_err=1, tx_z=0 after 16 cycles.
REQ-034 tx_ready held 0 for 5 cycles in DONE -> tx_z/tx_err stable, rx_ready=0, rx_valid pulses ignored.
REQ-035 rx_rst_n=0 for one cycle mid-RUN -> tx_valid never asserts for that operand; rx_ready=1 next cycle.
